// File: rtl/fetch_prefetch_pkg.sv
// Shared constants for the LC-3 prefetching fetch unit: opcodes, FSM encoding
// and the PCoffset field widths used for target sign extension.
package fetch_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b1100;

  localparam int BR_OFF_W  = 9;
  localparam int JSR_OFF_W = 11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_prefetch_if.sv
// Memory-port and decode-handshake bundle of the fetch unit.
// master = fetch unit, slave = memory/decode side.
interface fetch_prefetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr_out;
  logic              rd_en_out;
  logic              wea_out;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output addr_out, rd_en_out, wea_out, instr_out, instr_pc, instr_valid,
    input  mem_rdata, mem_rvalid, instr_ready
  );

  modport slave (
    input  addr_out, rd_en_out, wea_out, instr_out, instr_pc, instr_valid,
    output mem_rdata, mem_rvalid, instr_ready
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Prefetch FIFO holding {instruction, tag PC}; flush wins over push,
// and push into a full queue is accepted only when a pop frees the slot.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [W-1:0]           i_data,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/fetch_prefetch.sv
// LC-3 prefetching fetch unit: sequential reads into a DEPTH-entry queue,
// redirect on taken control flow. FETCH_PERF_EN adds redirect/drop counters.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_start,
  input  logic              resolve_valid,
  input  logic [3:0]        opCode_in,
  input  logic [10:0]       offset_in,
  input  logic              jsrr_in,
  input  logic [ADDR_W-1:0] reg_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [2:0]        br_nzp,
  input  logic [2:0]        result_nzp,
  output logic [ADDR_W-1:0] pc,
`ifdef FETCH_PERF_EN
  output logic [15:0]       redirect_cnt,
  output logic [15:0]       drop_cnt,
`endif
  fetch_prefetch_if.master  bus
);
  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     CREDIT_MAX = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);

  fetch_state_e             r_state;
  logic [ADDR_W-1:0]        r_pc;
  logic [ADDR_W-1:0]        r_addr;
  logic [ADDR_W-1:0]        r_tag_pc;
  logic                     r_rd_en;
  logic [CW-1:0]            r_outstanding;
  logic [CW-1:0]            r_discard;

  logic                     w_redirect;
  logic [ADDR_W-1:0]        w_target;
  logic [ADDR_W-1:0]        w_br_target;
  logic [ADDR_W-1:0]        w_jsr_target;
  logic [CW:0]              w_credits;
  logic                     w_issue;
  logic                     w_resp;
  logic                     w_drop;
  logic                     w_push;
  logic                     w_pop;
  logic [CW-1:0]            w_q_count;
  logic                     w_q_full;
  logic                     w_q_empty;
  logic [DATA_W+ADDR_W-1:0] w_q_head;

  assign w_br_target  = pc_in + {{(ADDR_W-BR_OFF_W){offset_in[BR_OFF_W-1]}}, offset_in[BR_OFF_W-1:0]};
  assign w_jsr_target = pc_in + {{(ADDR_W-JSR_OFF_W){offset_in[JSR_OFF_W-1]}}, offset_in};

  always_comb begin
    w_redirect = 1'b0;
    w_target   = reg_in;
    if (resolve_valid) begin
      case (opCode_in)
        OP_BR: begin
          w_redirect = |(br_nzp & result_nzp);
          w_target   = w_br_target;
        end
        OP_JMP: w_redirect = 1'b1;
        OP_JSR: begin
          w_redirect = 1'b1;
          w_target   = jsrr_in ? reg_in : w_jsr_target;
        end
        default: w_redirect = 1'b0;
      endcase
    end
  end

  // Discarded in-flight reads still hold queue slots until they come back.
  assign w_credits = {1'b0, r_outstanding} + {1'b0, r_discard} + {1'b0, w_q_count};
  assign w_issue   = (r_state == RUN) && fetch_start && !w_redirect && !w_q_full
                     && (w_credits < CREDIT_MAX);
  assign w_resp    = bus.mem_rvalid && ((r_outstanding != '0) || (r_discard != '0));
  assign w_drop    = w_resp && ((r_discard != '0) || w_redirect);
  assign w_push    = w_resp && !w_drop;
  assign w_pop     = bus.instr_valid && bus.instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_addr        <= '0;
      r_rd_en       <= 1'b0;
      r_tag_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      case (r_state)
        IDLE:    if (fetch_start)  r_state <= RUN;
        RUN:     if (!fetch_start) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      r_rd_en <= w_issue;
      if (w_issue) r_addr <= r_pc;
      if (w_redirect) begin
        r_pc          <= w_target;
        r_tag_pc      <= w_target;
        r_outstanding <= '0;
        r_discard     <= r_discard + r_outstanding - (w_resp ? CNT_ONE : '0);
      end else begin
        if (w_issue) r_pc     <= r_pc + ADDR_W'(1);
        if (w_push)  r_tag_pc <= r_tag_pc + ADDR_W'(1);
        r_outstanding <= r_outstanding + (w_issue ? CNT_ONE : '0) - (w_push ? CNT_ONE : '0);
        r_discard     <= r_discard - (w_drop ? CNT_ONE : '0);
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (DATA_W + ADDR_W)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_data  ({bus.mem_rdata, r_tag_pc}),
    .o_data  (w_q_head),
    .o_count (w_q_count),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  assign pc              = r_pc;
  assign bus.addr_out    = r_addr;
  assign bus.rd_en_out   = r_rd_en;
  assign bus.wea_out     = 1'b0;
  assign bus.instr_valid = !w_q_empty;
  assign bus.instr_out   = w_q_empty ? '0 : w_q_head[DATA_W+ADDR_W-1:ADDR_W];
  assign bus.instr_pc    = w_q_empty ? '0 : w_q_head[ADDR_W-1:0];

`ifdef FETCH_PERF_EN
  logic [15:0] r_redirect_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_cnt <= '0;
      r_drop_cnt     <= '0;
    end else begin
      if (w_redirect && (r_redirect_cnt != 16'hFFFF)) r_redirect_cnt <= r_redirect_cnt + 16'd1;
      if (w_drop && (r_drop_cnt != 16'hFFFF))         r_drop_cnt     <= r_drop_cnt + 16'd1;
    end
  end

  assign redirect_cnt = r_redirect_cnt;
  assign drop_cnt     = r_drop_cnt;
`endif
endmodule

// File: tb/tb_fetch_prefetch.sv
// Randomized bench for fetch_prefetch: transaction-level model of the fetch
// queue and in-flight reads, plus directed scenarios with literal expectations.
module tb_fetch_prefetch;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic        resolve_valid = 1'b0;
  logic [3:0]  opCode_in = '0;
  logic [10:0] offset_in = '0;
  logic        jsrr_in = 1'b0;
  logic [15:0] reg_in = '0;
  logic [15:0] pc_in = '0;
  logic [2:0]  br_nzp = '0;
  logic [2:0]  result_nzp = '0;
  logic [15:0] pc;
`ifdef FETCH_PERF_EN
  logic [15:0] redirect_cnt;
  logic [15:0] drop_cnt;
`endif

  fetch_prefetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_prefetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .resolve_valid(resolve_valid),
    .opCode_in(opCode_in), .offset_in(offset_in), .jsrr_in(jsrr_in), .reg_in(reg_in),
    .pc_in(pc_in), .br_nzp(br_nzp), .result_nzp(result_nzp), .pc(pc),
`ifdef FETCH_PERF_EN
    .redirect_cnt(redirect_cnt), .drop_cnt(drop_cnt),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat_min = 2;
  int lat_max = 2;
  int last_due = 0;
  bit spurious_en = 1'b0;

  typedef struct packed { logic [15:0] addr; bit stale; } req_t;
  typedef struct packed { logic [15:0] data; logic [15:0] pc; } ent_t;
  typedef struct packed { logic [15:0] addr; int due; } pend_t;
  typedef struct packed { logic [15:0] addr; int cyc; } ilog_t;

  // reference model state
  req_t        m_inflight[$];
  ent_t        m_q[$];
  logic [15:0] m_pc;
  logic [15:0] m_addr;
  bit          m_rd_en;
  bit          m_run;
  int          m_drops;
  int          m_redirects;

  pend_t pend[$];
  ilog_t ilog[$];
  ent_t  dlog[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_inflight.delete();
    m_q.delete();
    m_pc = 16'h0000;
    m_addr = 16'h0000;
    m_rd_en = 1'b0;
    m_run = 1'b0;
    m_drops = 0;
    m_redirects = 0;
  endfunction

  function automatic void model_step();
    bit redir;
    bit issue;
    bit pop;
    bit do_push;
    logic [15:0] tgt;
    req_t r;
    ent_t e;
    redir = 1'b0;
    tgt = 16'h0;
    do_push = 1'b0;
    e = '0;
    if (resolve_valid) begin
      if (opCode_in == 4'b0000 && (br_nzp & result_nzp) != 3'b000) begin
        redir = 1'b1;
        tgt = pc_in + 16'($signed(offset_in[8:0]));
      end else if (opCode_in == 4'b1100) begin
        redir = 1'b1;
        tgt = reg_in;
      end else if (opCode_in == 4'b0100) begin
        redir = 1'b1;
        tgt = jsrr_in ? reg_in : pc_in + 16'($signed(offset_in));
      end
    end
    issue = m_run && fetch_start && !redir && (m_inflight.size() + m_q.size() < DEPTH);
    pop = (m_q.size() > 0) && bus.instr_ready;
    if (bus.mem_rvalid && m_inflight.size() > 0) begin
      r = m_inflight.pop_front();
      if (r.stale || redir) m_drops++;
      else begin
        do_push = 1'b1;
        e.data = bus.mem_rdata;
        e.pc = r.addr;
      end
    end
    if (pop) m_q.delete(0);
    if (do_push) m_q.push_back(e);
    if (redir) begin
      m_q.delete();
      foreach (m_inflight[i]) m_inflight[i].stale = 1'b1;
      m_pc = tgt;
      m_redirects++;
    end
    if (issue) begin
      m_inflight.push_back('{addr: m_pc, stale: 1'b0});
      m_addr = m_pc;
      m_pc = m_pc + 16'h1;
    end
    m_rd_en = issue;
    m_run = fetch_start;
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    cyc++;
    #1;
    resolve_valid = 1'b0;
    bus.mem_rvalid = 1'b0;
    if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = pend[0].addr + 16'h1000;
      pend.delete(0);
    end else if (spurious_en && rst_n && pend.size() == 0 && m_inflight.size() == 0
                 && $urandom_range(0, 15) == 0) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = 16'($urandom);
    end
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    fetch_start = 1'b0;
    resolve_valid = 1'b0;
    bus.mem_rvalid = 1'b0;
    pend.delete();
    last_due = 0;
    model_reset();
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  // memory model, logging and per-cycle comparison against the model
  always @(negedge clk) begin
    int d;
    if (bus.rd_en_out) begin
      d = cyc + int'($urandom_range(lat_min, lat_max));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{addr: bus.addr_out, due: d});
      ilog.push_back('{addr: bus.addr_out, cyc: cyc});
    end
    if (bus.instr_valid && bus.instr_ready) dlog.push_back('{data: bus.instr_out, pc: bus.instr_pc});
    chk("pc", pc, m_pc);
    chk("addr_out", bus.addr_out, m_addr);
    chk("rd_en_out", bus.rd_en_out, m_rd_en);
    chk("wea_out", bus.wea_out, 0);
    chk("instr_valid", bus.instr_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("instr_out", bus.instr_out, m_q[0].data);
      chk("instr_pc", bus.instr_pc, m_q[0].pc);
    end
`ifdef FETCH_PERF_EN
    chk("redirect_cnt", redirect_cnt, (m_redirects > 65535) ? 65535 : m_redirects);
    chk("drop_cnt", drop_cnt, (m_drops > 65535) ? 65535 : m_drops);
`endif
  end

  initial begin
    bit found;
    int d0;
    int r0;
    logic [15:0] p0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    bus.instr_ready = 1'b0;
    model_reset();

    // reset values
    repeat (5) step();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_addr_out", bus.addr_out, 16'h0000);
    chk("rst_wea_out", bus.wea_out, 0);
    chk("rst_rd_en_out", bus.rd_en_out, 0);
    chk("rst_instr_valid", bus.instr_valid, 0);
    chk("rst_instr_out", bus.instr_out, 16'h0000);
    chk("rst_instr_pc", bus.instr_pc, 16'h0000);
    rst_n = 1'b1;

    // sequential streaming, latency 2
    lat_min = 2; lat_max = 2;
    bus.instr_ready = 1'b1;
    fetch_start = 1'b1;
    repeat (30) step();
    chk("stream_issue_count_ge4", ilog.size() >= 4, 1);
    if (ilog.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("stream_issue_addr", ilog[i].addr, i);
        if (i > 0) chk("stream_issue_consecutive", ilog[i].cyc - ilog[i-1].cyc, 1);
      end
    chk("stream_deliv_count_ge6", dlog.size() >= 6, 1);
    if (dlog.size() >= 6)
      for (int i = 0; i < 6; i++) begin
        chk("stream_deliv_pc", dlog[i].pc, i);
        chk("stream_deliv_data", dlog[i].data, 16'h1000 + i);
      end

    // decode stalled: credits cap the reads at DEPTH
    apply_reset(3);
    ilog.delete(); dlog.delete();
    bus.instr_ready = 1'b0;
    fetch_start = 1'b1;
    repeat (20) step();
    chk("stall_issue_count", ilog.size(), 4);
    chk("stall_pc", pc, 16'h0004);
    chk("stall_rd_en", bus.rd_en_out, 0);
    chk("stall_head_pc", bus.instr_pc, 16'h0000);
    chk("stall_head_valid", bus.instr_valid, 1);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    repeat (10) step();
    chk("stall_pop_issue_count", ilog.size(), 5);
    chk("stall_pop_pc", pc, 16'h0005);

    // taken BR with two reads in flight
    apply_reset(3);
    ilog.delete(); dlog.delete();
    lat_min = 6; lat_max = 6;
    bus.instr_ready = 1'b1;
    fetch_start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (pc == 16'h0002) found = 1'b1;
    end
    chk("br_wait_two_issued", found, 1);
    fetch_start = 1'b0;
    d0 = m_drops;
    resolve_valid = 1'b1; opCode_in = 4'b0000; pc_in = 16'h0005; offset_in = 11'h1FE;
    br_nzp = 3'b010; result_nzp = 3'b010; jsrr_in = 1'b0;
    step();
    chk("br_taken_pc", pc, 16'h0003);
    fetch_start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (dlog.size() > 0) found = 1'b1;
    end
    chk("br_first_deliv_seen", found, 1);
    if (found) begin
      chk("br_first_deliv_pc", dlog[0].pc, 16'h0003);
      chk("br_first_deliv_data", dlog[0].data, 16'h1003);
    end
    chk("br_model_drops", m_drops - d0, 2);

    // same BR, condition not met
    fetch_start = 1'b0;
    repeat (15) step();
    p0 = m_pc;
    r0 = m_redirects;
    resolve_valid = 1'b1; opCode_in = 4'b0000; pc_in = 16'h0005; offset_in = 11'h1FE;
    br_nzp = 3'b010; result_nzp = 3'b100;
    step();
    chk("br_not_taken_pc", pc, p0);
    chk("br_not_taken_model", m_redirects - r0, 0);
    fetch_start = 1'b1;
    repeat (10) step();

    // JMP, then reset in mid-stream
    lat_min = 1; lat_max = 3;
    resolve_valid = 1'b1; opCode_in = 4'b1100; reg_in = 16'h3000;
    step();
    chk("jmp_pc", pc, 16'h3000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.rd_en_out) found = 1'b1;
    end
    chk("jmp_issue_seen", found, 1);
    chk("jmp_addr_out", bus.addr_out, 16'h3000);
    repeat (3) step();
    rst_n = 1'b0;
    pend.delete();
    last_due = 0;
    bus.mem_rvalid = 1'b0;
    model_reset();
    #1;
    chk("midrst_pc", pc, 16'h0000);
    chk("midrst_addr_out", bus.addr_out, 16'h0000);
    chk("midrst_rd_en_out", bus.rd_en_out, 0);
    chk("midrst_instr_valid", bus.instr_valid, 0);
    chk("midrst_instr_out", bus.instr_out, 16'h0000);
    chk("midrst_instr_pc", bus.instr_pc, 16'h0000);
    apply_reset(2);

    // randomized traffic
    spurious_en = 1'b1;
    lat_min = 1; lat_max = 4;
    fetch_start = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 499) == 0) begin
        apply_reset(2);
        fetch_start = 1'b1;
      end
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) fetch_start = ~fetch_start;
      if ($urandom_range(0, 11) == 0) begin
        resolve_valid = 1'b1;
        case ($urandom_range(0, 3))
          0: opCode_in = 4'b0000;
          1: opCode_in = 4'b0100;
          2: opCode_in = 4'b1100;
          default: opCode_in = 4'($urandom_range(0, 15));
        endcase
        offset_in = 11'($urandom);
        pc_in = 16'($urandom);
        reg_in = 16'($urandom);
        br_nzp = 3'($urandom);
        result_nzp = 3'($urandom);
        jsrr_in = 1'($urandom);
      end
    end
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
